// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: destination scoreboard, operand forwarding
// selects, load-use stall and multi-cycle flush. Optional counters: HAZARD_STATS_EN.
module hazard_unit #(
    parameter int AWIDTH       = 5,
    parameter int FWD_STAGES   = 2,
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_DEPTH  = 2,
    parameter int SEL_W        = $clog2(FWD_STAGES + 1)
) (
    input  logic              h_clk,
    input  logic              h_rst,
    input  logic              h_i_valid,
    input  logic [AWIDTH-1:0] h_i_rs,
    input  logic [AWIDTH-1:0] h_i_rt,
    input  logic [AWIDTH-1:0] h_i_rd,
    input  logic              h_i_reg_wr,
    input  logic              h_i_mem_read,
    input  logic              h_i_change_pc,
    output logic              h_o_stall,
    output logic              h_o_flush,
    output logic [SEL_W-1:0]  h_o_fwd_rs,
    output logic [SEL_W-1:0]  h_o_fwd_rt
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       h_o_stall_cnt,
    output logic [31:0]       h_o_flush_cnt
`endif
);

    localparam int FCW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t                           r_state;
    logic [FCW-1:0]                   r_fcnt;
    logic [FWD_STAGES:1]              r_sb_vld;
    logic [FWD_STAGES:1]              r_sb_ld;
    logic [FWD_STAGES:1][AWIDTH-1:0]  r_sb_rd;

    logic              w_rs_nz, w_rt_nz;
    logic [SEL_W-1:0]  w_fwd_rs, w_fwd_rt;
    logic              w_load_hit, w_flush_act, w_stall, w_issue;

    assign w_rs_nz = (h_i_rs != '0);
    assign w_rt_nz = (h_i_rt != '0);

    // Scan from the oldest stage down so the nearest producer overwrites the select.
    always_comb begin
        w_fwd_rs   = '0;
        w_fwd_rt   = '0;
        w_load_hit = 1'b0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (r_sb_vld[k] && w_rs_nz && (r_sb_rd[k] == h_i_rs)) w_fwd_rs = SEL_W'(k);
            if (r_sb_vld[k] && w_rt_nz && (r_sb_rd[k] == h_i_rt)) w_fwd_rt = SEL_W'(k);
        end
        for (int k = 1; k <= LOAD_LATENCY; k++) begin
            if (r_sb_vld[k] && r_sb_ld[k] &&
                ((w_rs_nz && (r_sb_rd[k] == h_i_rs)) || (w_rt_nz && (r_sb_rd[k] == h_i_rt))))
                w_load_hit = 1'b1;
        end
    end

    assign w_flush_act = h_i_change_pc | (r_state == S_FLUSH);
    assign w_stall     = h_i_valid & ~w_flush_act & w_load_hit;
    assign w_issue     = h_i_valid & ~w_stall & ~w_flush_act;

    assign h_o_flush  = ~h_rst & w_flush_act;
    assign h_o_stall  = ~h_rst & w_stall;
    assign h_o_fwd_rs = h_rst ? '0 : w_fwd_rs;
    assign h_o_fwd_rt = h_rst ? '0 : w_fwd_rt;

    // r_fcnt holds the flush cycles still owed after the current one.
    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            r_sb_vld <= '0;
            r_sb_ld  <= '0;
            r_sb_rd  <= '0;
            r_state  <= S_IDLE;
            r_fcnt   <= '0;
        end else begin
            for (int k = 2; k <= FWD_STAGES; k++) begin
                r_sb_vld[k] <= r_sb_vld[k-1];
                r_sb_ld[k]  <= r_sb_ld[k-1];
                r_sb_rd[k]  <= r_sb_rd[k-1];
            end
            r_sb_vld[1] <= w_issue & h_i_reg_wr & (h_i_rd != '0);
            r_sb_ld[1]  <= w_issue & h_i_mem_read;
            r_sb_rd[1]  <= h_i_rd;

            if (h_i_change_pc) begin
                r_fcnt  <= FCW'(FLUSH_DEPTH - 1);
                r_state <= (FLUSH_DEPTH > 1) ? S_FLUSH : S_IDLE;
            end else if (r_state == S_FLUSH) begin
                if (r_fcnt <= FCW'(1)) begin
                    r_fcnt  <= '0;
                    r_state <= S_IDLE;
                end else begin
                    r_fcnt <= r_fcnt - FCW'(1);
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (h_i_change_pc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign h_o_stall_cnt = r_stall_cnt;
    assign h_o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, reset-mid-stall sequence, then random
// traffic scored against a queue-based model of the in-flight instruction history.
module tb_hazard_unit;
    localparam int AW = 5;
    localparam int FS = 2;
    localparam int LL = 1;
    localparam int FD = 2;
    localparam int SW = $clog2(FS + 1);

    logic          h_clk = 1'b0;
    logic          h_rst, h_i_valid, h_i_reg_wr, h_i_mem_read, h_i_change_pc;
    logic [AW-1:0] h_i_rs, h_i_rt, h_i_rd;
    logic          h_o_stall, h_o_flush;
    logic [SW-1:0] h_o_fwd_rs, h_o_fwd_rt;
`ifdef HAZARD_STATS_EN
    logic [31:0]   h_o_stall_cnt, h_o_flush_cnt;
`endif

    always #5 h_clk = ~h_clk;

    hazard_unit #(.AWIDTH(AW), .FWD_STAGES(FS), .LOAD_LATENCY(LL), .FLUSH_DEPTH(FD)) dut (
        .h_clk(h_clk), .h_rst(h_rst), .h_i_valid(h_i_valid),
        .h_i_rs(h_i_rs), .h_i_rt(h_i_rt), .h_i_rd(h_i_rd),
        .h_i_reg_wr(h_i_reg_wr), .h_i_mem_read(h_i_mem_read), .h_i_change_pc(h_i_change_pc),
        .h_o_stall(h_o_stall), .h_o_flush(h_o_flush),
        .h_o_fwd_rs(h_o_fwd_rs), .h_o_fwd_rt(h_o_fwd_rt)
`ifdef HAZARD_STATS_EN
        , .h_o_stall_cnt(h_o_stall_cnt), .h_o_flush_cnt(h_o_flush_cnt)
`endif
    );

    typedef struct {
        bit rst, valid, wr, mr, cpc;
        int rs, rt, rd;
        int stall, flush, frs, frt;
    } vec_t;

    typedef struct { bit v; bit ld; int rd; } ent_t;

    vec_t tbl[$];
    ent_t hist[$];
    int   flush_left;
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic vec_t mk(bit rst, bit valid, int rs, int rt, int rd, bit wr, bit mr,
                                bit cpc, int stall, int flush, int frs, int frt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rs = rs; v.rt = rt; v.rd = rd;
        v.wr = wr; v.mr = mr; v.cpc = cpc;
        v.stall = stall; v.flush = flush; v.frs = frs; v.frt = frt;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        h_rst = v.rst; h_i_valid = v.valid; h_i_change_pc = v.cpc;
        h_i_reg_wr = v.wr; h_i_mem_read = v.mr;
        h_i_rs = AW'(v.rs); h_i_rt = AW'(v.rt); h_i_rd = AW'(v.rd);
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".stall"},  int'(h_o_stall),  v.stall);
        chk({tag, ".flush"},  int'(h_o_flush),  v.flush);
        chk({tag, ".fwd_rs"}, int'(h_o_fwd_rs), v.frs);
        chk({tag, ".fwd_rt"}, int'(h_o_fwd_rt), v.frt);
    endtask

    task automatic cyc(input string tag, input vec_t v);
        drive(v);
        @(negedge h_clk);
        check_outs(tag, v);
        @(posedge h_clk);
        #1;
    endtask

    // Reference: expected outputs from the list of the last FS issued slots.
    function automatic vec_t model_eval(input vec_t v);
        vec_t e = v;
        bit hit = 0;
        e.stall = 0; e.flush = 0; e.frs = 0; e.frt = 0;
        if (v.rst) return e;
        e.flush = (v.cpc || flush_left > 0) ? 1 : 0;
        for (int i = FS - 1; i >= 0; i--) begin
            if (hist[i].v && v.rs != 0 && hist[i].rd == v.rs) e.frs = i + 1;
            if (hist[i].v && v.rt != 0 && hist[i].rd == v.rt) e.frt = i + 1;
        end
        for (int i = 0; i < LL; i++)
            if (hist[i].v && hist[i].ld &&
                ((v.rs != 0 && hist[i].rd == v.rs) || (v.rt != 0 && hist[i].rd == v.rt))) hit = 1;
        e.stall = (v.valid && !e.flush && hit) ? 1 : 0;
        return e;
    endfunction

    task automatic model_step(input vec_t e);
        ent_t n;
        if (e.rst) begin
            hist.delete();
            for (int i = 0; i < FS; i++) hist.push_back('{v: 0, ld: 0, rd: 0});
            flush_left = 0;
            return;
        end
        n.v  = e.valid && !e.stall && !e.flush && e.wr && e.rd != 0;
        n.ld = e.valid && !e.stall && !e.flush && e.mr;
        n.rd = e.rd;
        hist.push_front(n);
        void'(hist.pop_back());
        if (e.cpc) flush_left = FD - 1;
        else if (flush_left > 0) flush_left--;
    endtask

    initial begin
        flush_left = 0;
        //         rst v  rs rt rd  wr mr cpc | stall flush frs frt
        tbl.push_back(mk(1, 1, 3, 3, 3, 1, 1, 1,  0, 0, 0, 0)); // reset forces zeros
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 2, 3, 1, 0, 0,  0, 0, 0, 0)); // add $3,$1,$2
        tbl.push_back(mk(0, 1, 3, 5, 4, 1, 0, 0,  0, 0, 1, 0)); // sub $4,$3,$5
        tbl.push_back(mk(0, 1, 3, 4, 6, 1, 0, 0,  0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0)); // write $3
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0)); // write $3 again
        tbl.push_back(mk(0, 1, 3, 3, 10, 1, 0, 0, 0, 0, 1, 1)); // nearest wins
        tbl.push_back(mk(0, 1, 3, 0, 11, 1, 0, 0, 0, 0, 2, 0)); // one intervening
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0)); // write $0
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // read $0
        tbl.push_back(mk(0, 1, 1, 0, 8, 1, 1, 0,  0, 0, 0, 0)); // lw $8
        tbl.push_back(mk(0, 1, 8, 8, 9, 1, 0, 0,  1, 0, 1, 1)); // load-use stall
        tbl.push_back(mk(0, 1, 8, 8, 9, 1, 0, 0,  0, 0, 2, 2)); // released
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0)); // change_pc
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0)); // change_pc
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0)); // reload
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8, 1, 1, 0,  0, 0, 0, 0)); // lw $8
        tbl.push_back(mk(0, 1, 8, 8, 9, 1, 0, 1,  0, 1, 1, 1)); // flush beats stall
        tbl.push_back(mk(0, 1, 9, 8, 0, 0, 0, 0,  0, 1, 0, 2)); // $9 never entered
        tbl.push_back(mk(0, 1, 9, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0)); // lw $5
        tbl.push_back(mk(0, 1, 5, 0, 6, 1, 0, 1,  0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 5, 5, 6, 1, 0, 0,  0, 0, 0, 0)); // reset mid-flush
        tbl.push_back(mk(0, 1, 5, 5, 6, 1, 0, 0,  0, 0, 0, 0)); // empty afterwards

        drive(tbl[0]);
        #1;
        foreach (tbl[i]) begin
            cyc($sformatf("row%0d", i), tbl[i]);
`ifdef HAZARD_STATS_EN
            if (i == 2)  chk("stall_cnt_reset", int'(h_o_stall_cnt), 0);
            if (i == 14) chk("stall_cnt_one", int'(h_o_stall_cnt), 1);
`endif
        end

        // Reset asserted while a load-use stall is pending.
        cyc("rs_lw",    mk(0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
        cyc("rs_stall", mk(0, 1, 7, 1, 2, 1, 0, 0, 1, 0, 1, 0));
        cyc("rs_rst",   mk(1, 1, 7, 1, 2, 1, 0, 0, 0, 0, 0, 0));
        cyc("rs_after", mk(0, 1, 7, 1, 2, 1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 400; i++) begin
            vec_t v, e;
            v = mk(i == 0 || $urandom_range(0, 49) == 0, 1'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                   $urandom_range(0, 7) == 0, 0, 0, 0, 0);
            e = model_eval(v);
            cyc($sformatf("rnd%0d", i), e);
            model_step(e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised pipeline hazard controller for the five-stage MIPS datapath. It tracks the destination register of every in-flight instruction in a depth-configurable scoreboard. From that it produces forwarding selects for the decode-stage operands, load-use stalls, and multi-cycle flushes on taken branches/PC changes. It sits beside `decoder_stage`/`execute`, fed from decode and from the execute stage's change-PC signal.

## Interface
Parameters:
- `AWIDTH`, 5: register-address width.
- `FWD_STAGES`, 2: downstream stages tracked/forwardable (EX, MEM, ...); ≥1.
- `LOAD_LATENCY`, 1: stages after issue in which a load result is not yet forwardable; 1 ≤ `LOAD_LATENCY` ≤ `FWD_STAGES`.
- `FLUSH_DEPTH`, 2: cycles `h_o_flush` is held per PC change; ≥1.
- `SEL_W`, `$clog2(FWD_STAGES+1)`: forwarding-select width.

Ports:
- `h_clk` in 1: clock.
- `h_rst` in 1: synchronous, active-high reset.
- `h_i_valid` in 1: decode stage holds a valid instruction.
- `h_i_rs`, `h_i_rt` in `AWIDTH`: source registers of the decode instruction.
- `h_i_rd` in `AWIDTH`: destination register, already muxed by RegDst.
- `h_i_reg_wr` in 1: decode instruction writes the register file.
- `h_i_mem_read` in 1: decode instruction is a load.
- `h_i_change_pc` in 1: execute stage redirects the PC this cycle.
- `h_o_stall` out 1: hold PC and IF/ID, inject bubble into ID/EX.
- `h_o_flush` out 1: kill IF/ID and ID/EX contents.
- `h_o_fwd_rs`, `h_o_fwd_rt` out `SEL_W`: 0 = register file, k = result of scoreboard stage k.
- `h_o_stall_cnt`, `h_o_flush_cnt` out 32: event counters, only with `HAZARD_STATS_EN`.

## Operation
- Scoreboard: shift register `sb[1..FWD_STAGES]` of records {valid, rd, load}. It advances every cycle: `sb[k+1] <= sb[k]`, and the last entry drops out.
- Entry into `sb[1]`: if `h_i_valid & ~h_o_stall & ~h_o_flush`, load {`h_i_reg_wr & (h_i_rd != 0)`, `h_i_rd`, `h_i_mem_read`}. Otherwise load a bubble (valid=0).
- Forwarding for each source `s` in {rs, rt}:
  - Select the lowest k with `sb[k].valid & sb[k].rd == s & s != 0`; nearest stage wins.
  - If there is no match, select 0.
  - Register 0 is never forwarded.
- Load-use: `h_o_stall` = `h_i_valid & ~flush_active` and any k ≤ `LOAD_LATENCY` with `sb[k].valid & sb[k].load & sb[k].rd` matching a nonzero `h_i_rs`/`h_i_rt`.
- During a stall, forwarding selects are don't-care to consumers. The unit still outputs the computed values.
- Stall self-clears once the load has shifted past stage `LOAD_LATENCY`, because bubbles enter behind it.
- Flush FSM: states IDLE, FLUSH.
  - IDLE→FLUSH when `h_i_change_pc`; counter `fcnt <= FLUSH_DEPTH-1`.
  - In FLUSH: decrement; return to IDLE when `fcnt==0`.
  - A new `h_i_change_pc` while in FLUSH reloads `fcnt` to `FLUSH_DEPTH-1`.
- `flush_active` = `h_i_change_pc | (state==FLUSH)`; `h_o_flush = flush_active`.
- Flush has priority over stall: `h_o_stall=0` whenever `flush_active`.
- Comparisons are full `AWIDTH`-bit equality. No arithmetic on addresses.

## Timing
- Reset (`h_rst` high at a rising edge):
  - All scoreboard entries invalid, state IDLE, `fcnt=0`, counters 0.
  - While `h_rst` is asserted, all outputs are forced 0.
- `h_o_stall`, `h_o_flush` and the fwd selects are combinational from current inputs and registered state, valid in the same cycle.
- A producer issued in cycle n is visible as stage k in cycle n+k.
- `h_o_flush` is high in the `h_i_change_pc` cycle plus `FLUSH_DEPTH-1` following cycles. With `FLUSH_DEPTH=1` it is a single-cycle pulse.
- Reset asserted mid-flush or mid-stall aborts immediately. The cycle after reset deasserts behaves as an empty pipeline.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `h_o_stall_cnt` increments every cycle `h_o_stall=1`.
  - `h_o_flush_cnt` increments on every IDLE→FLUSH or reload event.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports and counters are absent.

## Test plan
- Reset, then idle: all outputs 0; `lw`-free stream with no dependencies gives `fwd_rs=fwd_rt=0` and no stall.
- EX forward: issue `add $3,$1,$2`, next cycle decode `sub $4,$3,$5` → `h_o_fwd_rs=1`, `h_o_fwd_rt=0`, `h_o_stall=0`.
- Nearest-wins: write `$3` in two consecutive instructions, then read `$3` → `fwd=1`. Reading `$3` after one intervening instruction gives `fwd=2`. Reading `$0` after writing `$0` gives `fwd=0`.
- Load-use: `lw $8,0($1)` then `add $9,$8,$8` → `h_o_stall=1` for exactly one cycle. The following cycle has `h_o_stall=0`, `h_o_fwd_rs=h_o_fwd_rt=2`.
- Flush: `h_i_change_pc` pulse with `FLUSH_DEPTH=2` → flush high 2 cycles. A second pulse in the flush's 2nd cycle extends it to 3 total. A simultaneous load-use condition gives `stall=0` and the scoreboard receives bubbles.
- Reset during flush: assert `h_rst` in the 1st flush cycle → outputs 0 next cycle, with no residual flush. With `HAZARD_STATS_EN`, check that counters read 0, then 1 stall after the load-use test.
